// File: rtl/time_of_day_alarm.sv
// Time-of-day counter with alarm compare and ring/snooze control.
// Advances HH:MM:SS on each rising edge of the 1 Hz input.
module time_of_day_alarm #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec_clock,
  input  logic       time_set,
  input  logic       alarm_set,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       alarm_enable,
  input  logic       snooze,
  input  logic       alarm_off,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       sec_tick,
  output logic       alarm_ring
);

  localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam int SW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECONDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZING
  } state_t;

  logic          prev_q;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [4:0]    ahour_q, ahour_d;
  logic [5:0]    amin_q, amin_d;
  logic          tick_q, tick_d;
  logic          ring_q, ring_d;
  state_t        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;

  logic       tick;
  logic       set_ok;
  logic       match;
  logic [4:0] nxt_hour;
  logic [5:0] nxt_min;
  logic [5:0] nxt_sec;

  // Tick detect, next-time arithmetic, time and alarm registers
  always_comb begin
    tick   = one_sec_clock & ~prev_q;
    set_ok = (set_hour <= 5'd23) && (set_min <= 6'd59);

    nxt_sec  = sec_q;
    nxt_min  = min_q;
    nxt_hour = hour_q;
    if (sec_q == 6'd59) begin
      nxt_sec = 6'd0;
      if (min_q == 6'd59) begin
        nxt_min  = 6'd0;
        nxt_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end else begin
        nxt_min = min_q + 6'd1;
      end
    end else begin
      nxt_sec = sec_q + 6'd1;
    end

    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (time_set) begin
      if (set_ok) begin
        hour_d = set_hour;
        min_d  = set_min;
        sec_d  = 6'd0;
      end
    end else if (tick) begin
      hour_d = nxt_hour;
      min_d  = nxt_min;
      sec_d  = nxt_sec;
    end

    ahour_d = ahour_q;
    amin_d  = amin_q;
    if (alarm_set && set_ok) begin
      ahour_d = set_hour;
      amin_d  = set_min;
    end

    match = tick && !time_set
         && (nxt_hour == ahour_q)
         && (nxt_min == amin_q)
         && (nxt_sec == 6'd0);
    tick_d = tick;
  end

  // Ring/snooze state machine: next state and counters
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (alarm_enable && !alarm_off && !snooze && match) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (!alarm_enable || alarm_off) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d   = SNOOZING;
          snz_cnt_d = '0;
        end else if (tick) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d = IDLE;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
      end
      SNOOZING: begin
        if (!alarm_enable || alarm_off) begin
          state_d = IDLE;
        end else if (tick) begin
          if (snz_cnt_q == SNZ_LAST) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ring_d = (state_d == RINGING);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= one_sec_clock;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      ahour_q    <= '0;
      amin_q     <= '0;
      tick_q     <= 1'b0;
      ring_q     <= 1'b0;
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      prev_q     <= one_sec_clock;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      ahour_q    <= ahour_d;
      amin_q     <= amin_d;
      tick_q     <= tick_d;
      ring_q     <= ring_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign hour       = hour_q;
  assign minute     = min_q;
  assign second     = sec_q;
  assign alarm_hour = ahour_q;
  assign alarm_min  = amin_q;
  assign sec_tick   = tick_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_time_of_day_alarm.sv
// Scoreboard bench for time_of_day_alarm.
// Expected output words are queued with stimulus, popped after the edge.
module tb_time_of_day_alarm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_sec_clock = 1'b0;
  logic       time_set = 1'b0;
  logic       alarm_set = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic       alarm_enable = 1'b0;
  logic       snooze = 1'b0;
  logic       alarm_off = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       sec_tick;
  logic       alarm_ring;

  time_of_day_alarm #(
    .RING_SECONDS  (4),
    .SNOOZE_SECONDS(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .one_sec_clock(one_sec_clock),
    .time_set     (time_set),
    .alarm_set    (alarm_set),
    .set_hour     (set_hour),
    .set_min      (set_min),
    .alarm_enable (alarm_enable),
    .snooze       (snooze),
    .alarm_off    (alarm_off),
    .hour         (hour),
    .minute       (minute),
    .second       (second),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .sec_tick     (sec_tick),
    .alarm_ring   (alarm_ring)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [29:0] exp_q[$];
  logic [29:0] ex;
  logic [29:0] obs;
  int th, tm, ts, ah, am;

  assign obs = {hour, minute, second, alarm_hour, alarm_min,
                sec_tick, alarm_ring};

  function automatic logic [29:0] pk(int h, int m, int s,
                                     int t, int r);
    return {5'(h), 6'(m), 6'(s), 5'(ah), 6'(am), 1'(t), 1'(r)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    if (ts == 59) begin
      ts = 0;
      if (tm == 59) begin
        tm = 0;
        th = (th == 23) ? 0 : th + 1;
      end else tm = tm + 1;
    end else ts = ts + 1;
  endtask

  task automatic pulse();
    one_sec_clock = 1'b1;
    cyc();
    adv();
    one_sec_clock = 1'b0;
    cyc();
  endtask

  task automatic ring_up();
    time_set = 1'b1;
    set_hour = 5'd7;
    set_min  = 6'd29;
    cyc();
    time_set = 1'b0;
    th = 7; tm = 29; ts = 0;
    for (int i = 0; i < 60; i++) pulse();
  endtask

  task automatic test_reset();
    ah = 0; am = 0;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, ex);
    end
  endtask

  task automatic test_rollover();
    time_set = 1'b1;
    set_hour = 5'd23;
    set_min  = 6'd59;
    th = 23; tm = 59; ts = 0;
    exp_q.push_back(pk(th, tm, ts, 0, 0));
    cyc();
    time_set = 1'b0;
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL rollover_load: got %h expected %h", obs, ex);
    end
    for (int i = 0; i < 60; i++) begin
      one_sec_clock = 1'b1;
      adv();
      exp_q.push_back(pk(th, tm, ts, 1, 0));
      cyc();
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL rollover_rise%0d: got %h expected %h", i, obs, ex);
      end
      one_sec_clock = 1'b0;
      exp_q.push_back(pk(th, tm, ts, 0, 0));
      cyc();
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL rollover_fall%0d: got %h expected %h", i, obs, ex);
      end
    end
    checks++;
    if ({hour, minute, second} !== 17'd0) begin
      errors++;
      $display("FAIL rollover_final: got %0d:%0d:%0d expected 0:0:0",
               hour, minute, second);
    end
  endtask

  task automatic test_range();
    logic [10:0] tbl [3];
    tbl[0] = {5'd24, 6'd10};
    tbl[1] = {5'd12, 6'd60};
    tbl[2] = {5'd12, 6'd34};
    for (int i = 0; i < 3; i++) begin
      time_set = 1'b1;
      {set_hour, set_min} = tbl[i];
      if (set_hour <= 23 && set_min <= 59) begin
        th = set_hour; tm = set_min; ts = 0;
      end
      exp_q.push_back(pk(th, tm, ts, 0, 0));
      cyc();
      time_set = 1'b0;
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL range%0d: got %h expected %h", i, obs, ex);
      end
    end
  endtask

  task automatic test_alarm_trigger();
    alarm_set = 1'b1;
    set_hour  = 5'd7;
    set_min   = 6'd30;
    ah = 7; am = 30;
    exp_q.push_back(pk(th, tm, ts, 0, 0));
    cyc();
    alarm_set = 1'b0;
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL alarm_set: got %h expected %h", obs, ex);
    end
    alarm_enable = 1'b1;
    time_set = 1'b1;
    set_hour = 5'd7;
    set_min  = 6'd29;
    cyc();
    time_set = 1'b0;
    th = 7; tm = 29; ts = 0;
    for (int i = 0; i < 58; i++) pulse();
    for (int i = 0; i < 6; i++) begin
      one_sec_clock = 1'b1;
      adv();
      exp_q.push_back(pk(th, tm, ts, 1, (i >= 1 && i <= 4) ? 1 : 0));
      cyc();
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL trigger%0d: got %h expected %h", i, obs, ex);
      end
      one_sec_clock = 1'b0;
      cyc();
    end
  endtask

  task automatic test_snooze();
    ring_up();
    exp_q.push_back(pk(7, 30, 0, 0, 1));
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL snooze_ring: got %h expected %h", obs, ex);
    end
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    checks++;
    if (alarm_ring !== 1'b0) begin
      errors++;
      $display("FAIL snooze_drop: got %b expected 0", alarm_ring);
    end
    for (int i = 0; i < 3; i++) begin
      one_sec_clock = 1'b1;
      adv();
      exp_q.push_back(pk(th, tm, ts, 1, (i == 2) ? 1 : 0));
      cyc();
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL snooze_tick%0d: got %h expected %h", i, obs, ex);
      end
      one_sec_clock = 1'b0;
      cyc();
    end
    alarm_off = 1'b1;
    cyc();
    cyc();
    cyc();
    alarm_off = 1'b0;
    for (int i = 0; i < 5; i++) begin
      one_sec_clock = 1'b1;
      adv();
      exp_q.push_back(pk(th, tm, ts, 1, 0));
      cyc();
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL off_tick%0d: got %h expected %h", i, obs, ex);
      end
      one_sec_clock = 1'b0;
      cyc();
    end
  endtask

  task automatic test_priority();
    ring_up();
    snooze    = 1'b1;
    alarm_off = 1'b1;
    cyc();
    snooze    = 1'b0;
    alarm_off = 1'b0;
    for (int i = 0; i < 4; i++) begin
      one_sec_clock = 1'b1;
      adv();
      exp_q.push_back(pk(th, tm, ts, 1, 0));
      cyc();
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL prio_idle%0d: got %h expected %h", i, obs, ex);
      end
      one_sec_clock = 1'b0;
      cyc();
    end
    time_set = 1'b1;
    set_hour = 5'd10;
    set_min  = 6'd20;
    one_sec_clock = 1'b1;
    th = 10; tm = 20; ts = 0;
    exp_q.push_back(pk(th, tm, ts, 1, 0));
    cyc();
    time_set = 1'b0;
    one_sec_clock = 1'b0;
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL prio_set_tick: got %h expected %h", obs, ex);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    ring_up();
    pulse();
    pulse();
    exp_q.push_back(pk(7, 30, 2, 0, 1));
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL mid_ringing: got %h expected %h", obs, ex);
    end
    one_sec_clock = 1'b1;
    reset = 1'b1;
    ah = 0; am = 0;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    exp_q.push_back(pk(0, 0, 1, 1, 0));
    cyc();
    reset = 1'b0;
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", obs, ex);
    end
    cyc();
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL mid_no_tick: got %h expected %h", obs, ex);
    end
    one_sec_clock = 1'b0;
    cyc();
    one_sec_clock = 1'b1;
    cyc();
    ex = exp_q.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL mid_first_tick: got %h expected %h", obs, ex);
    end
    one_sec_clock = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_range();
    test_alarm_trigger();
    test_snooze();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/time_of_day_alarm.md
# time_of_day_alarm

Time-of-day counter and alarm controller driven by the 1 Hz square wave from `one_second_clock`. It sits directly downstream of that divider. It detects each rising edge of `one_sec_clock` in the `clk` domain and advances a 24-hour HH:MM:SS count. It compares the count against a user-set alarm time and runs a ring/snooze state machine whose outputs feed the display and buzzer logic.

## Interface
- `RING_SECONDS`, 60: ticks the alarm rings before auto-stopping.
- `SNOOZE_SECONDS`, 300: ticks spent in snooze before ringing again.
- `clk`  in  1  system clock (50 MHz; same clock as `one_second_clock`).
- `reset`  in  1  synchronous, active-high reset.
- `one_sec_clock`  in  1  1 Hz square wave from the upstream divider, synchronous to `clk`.
- `time_set`  in  1  level; load time from `set_hour`/`set_min`.
- `alarm_set`  in  1  level; load alarm from `set_hour`/`set_min`.
- `set_hour`  in  5  hour value to load, 0–23.
- `set_min`  in  6  minute value to load, 0–59.
- `alarm_enable`  in  1  arms the alarm; low forces IDLE.
- `snooze`  in  1  level; request snooze while ringing.
- `alarm_off`  in  1  level; stop the alarm.
- `hour`  out  5  current hour, 0–23.
- `minute`  out  6  current minute, 0–59.
- `second`  out  6  current second, 0–59.
- `alarm_hour`  out  5  stored alarm hour.
- `alarm_min`  out  6  stored alarm minute.
- `sec_tick`  out  1  one-cycle pulse in the cycle the time advances.
- `alarm_ring`  out  1  high while in RINGING.

## Operation
- **Edge detect:** `prev` register holds the last sample of `one_sec_clock`. The internal tick is `one_sec_clock & ~prev`. During `reset`, `prev` loads `one_sec_clock`, so there is no spurious tick after reset.
- **Time counter:** on a tick, `second` increments.
  - 59 wraps to 0 and carries into `minute`.
  - `minute` 59 wraps to 0 and carries into `hour`.
  - `hour` 23 wraps to 0.
  - All arithmetic is unsigned; no value outside range is ever stored.
- **time_set:** while high, `hour`←`set_hour`, `minute`←`set_min`, `second`←0 every cycle, and ticks do not advance the time.
  - The load is ignored entirely (registers hold) if `set_hour`>23 or `set_min`>59.
  - If `time_set` and a tick coincide, the load wins and `sec_tick` still pulses.
- **alarm_set:** loads `alarm_hour`/`alarm_min` under the same range rule. Legal in any FSM state; it never changes state.
- **Match:** true when a tick (not a `time_set` load) produces next time == `alarm_hour`:`alarm_min`:00.
- **FSM states:** IDLE, RINGING, SNOOZING. Transition priority per cycle: `reset` > `!alarm_enable` > `alarm_off` > `snooze` > counter expiry > match.
  - IDLE→RINGING on match with `alarm_enable`; `ring_cnt`←0.
  - RINGING→IDLE on `alarm_off`, on `!alarm_enable`, or on a tick when `ring_cnt`==RING_SECONDS-1.
  - RINGING→SNOOZING on `snooze`; `snz_cnt`←0.
  - RINGING: each tick increments `ring_cnt`.
  - SNOOZING→RINGING on a tick when `snz_cnt`==SNOOZE_SECONDS-1; `ring_cnt`←0.
  - SNOOZING→IDLE on `alarm_off` or `!alarm_enable`.
  - SNOOZING: each tick increments `snz_cnt`.
  - A match while RINGING/SNOOZING is ignored.
- **Counter widths:** `ring_cnt`/`snz_cnt` widths are `$clog2` of their parameter, minimum 1.
- **Outputs:** `alarm_ring` = (state==RINGING), registered.

## Timing
- All outputs are registered. Reset values: `hour`=0, `minute`=0, `second`=0, `alarm_hour`=0, `alarm_min`=0, `sec_tick`=0, `alarm_ring`=0; state IDLE; counters 0.
- **Tick latency:** edge N is the first `clk` edge sampling `one_sec_clock`=1 after 0. At edge N, `second` updates and `sec_tick` goes high for exactly one cycle (N to N+1).
- **Alarm latency:** `alarm_ring` rises on the same edge the time becomes alarm:00. It falls on the edge after `alarm_off` or `snooze` is sampled high.
- **Set latency:** `time_set`/`alarm_set` values are visible on outputs one cycle after being sampled.
- **Reset mid-operation:** one reset cycle returns all state to reset values, including when RINGING.
- **Held inputs:** `snooze`/`alarm_off` held high across several cycles act once; with state already changed, they have no further effect.

## Test plan
- **Rollover:** `time_set` 23:59, release, apply 60 edges → `sec_tick` ×60; time 00:00:00; one `sec_tick` per edge, none on falling edges.
- **Range check:** `time_set` with `set_hour`=24, `set_min`=10 → time unchanged. With 12:60 → unchanged. With 12:34 → 12:34:00.
- **Alarm trigger:** alarm 07:30, enable, time 07:29:58, 2 edges → `alarm_ring` rises with `second`=0, `minute`=30. With RING_SECONDS=4 → drops after 4 more ticks.
- **Snooze:** SNOOZE_SECONDS=3; while ringing, pulse `snooze` → `alarm_ring`=0. After 3 ticks → `alarm_ring`=1. `alarm_off` → 0 and stays 0 across further ticks.
- **Priority:** `snooze` and `alarm_off` high the same cycle → IDLE. `time_set` coincident with a tick → loaded value, `second`=0, `sec_tick`=1.
- **Reset:** reset while RINGING at 07:30:02 → next cycle all outputs 0, IDLE. `reset` released with `one_sec_clock`=1 → no tick until the next rising edge.
